// File: rtl/timer_irq_source.sv
// Programmable down-counting timer with prescaler that raises a CPU interrupt on expiry.
// Interrupt is held until acknowledged; expiries that arrive while it is pending set a sticky overflow flag.
module timer_irq_source #(
   parameter int CNT_W = 16,
   parameter int PRE_W = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   input  logic       s_finish_interr,
   output logic       i_timer,
   output logic       overflow
);

   localparam int HALF = CNT_W / 2;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [PRE_W-1:0] PreOne = PRE_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic [PRE_W-1:0] preCnt_q, preCnt_d;
   logic             enable_q, enable_d;
   logic             autoReload_q, autoReload_d;
   logic             running_q, running_d;
   logic             overflow_q, overflow_d;

   logic             tick;
   logic             expiry;
   logic             irqActive;

   assign tick      = running_q && (preCnt_q == prescale_q);
   assign expiry    = tick && (count_q == '0);
   assign irqActive = (state_q == PEND);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A coincident expiry always beats the acknowledge, so the request never drops on an expiry edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (running_d) state_d = RUN;
         end
         RUN: begin
            if (expiry)          state_d = PEND;
            else if (!running_d) state_d = IDLE;
         end
         PEND: begin
            if (s_finish_interr && !expiry) state_d = running_d ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      i_timer  = irqActive;
      overflow = overflow_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload_q     <= '0;
         count_q      <= '0;
         prescale_q   <= '0;
         preCnt_q     <= '0;
         enable_q     <= 1'b0;
         autoReload_q <= 1'b0;
         running_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         reload_q     <= reload_d;
         count_q      <= count_d;
         prescale_q   <= prescale_d;
         preCnt_q     <= preCnt_d;
         enable_q     <= enable_d;
         autoReload_q <= autoReload_d;
         running_q    <= running_d;
         overflow_q   <= overflow_d;
      end
   end

   // Counting runs first; CPU writes then override, and the load check sees a one-shot that just stopped.
   always_comb begin
      reload_d     = reload_q;
      count_d      = count_q;
      prescale_d   = prescale_q;
      preCnt_d     = preCnt_q;
      enable_d     = enable_q;
      autoReload_d = autoReload_q;
      running_d    = running_q;
      overflow_d   = overflow_q;

      if (running_q) begin
         preCnt_d = tick ? '0 : preCnt_q + PreOne;
         if (tick) begin
            if (count_q != '0) begin
               count_d = count_q - CntOne;
            end else if (autoReload_q) begin
               count_d = reload_q;
            end else begin
               running_d = 1'b0;
               enable_d  = 1'b0;
            end
         end
      end

      if (we) begin
         case (addr)
            2'd0: reload_d[HALF-1:0]     = wdata[HALF-1:0];
            2'd1: reload_d[CNT_W-1:HALF] = wdata[HALF-1:0];
            2'd2: prescale_d             = wdata[PRE_W-1:0];
            2'd3: begin
               enable_d     = wdata[0];
               autoReload_d = wdata[1];
               if (!wdata[0]) begin
                  running_d = 1'b0;
               end else if (!running_d) begin
                  count_d   = reload_q;
                  preCnt_d  = '0;
                  running_d = 1'b1;
               end
               if (wdata[2]) overflow_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (expiry && irqActive && !s_finish_interr) overflow_d = 1'b1;
   end

   always_comb begin
      rdata = 8'h00;
      case (addr)
         2'd0: rdata = 8'(count_q[HALF-1:0]);
         2'd1: rdata = 8'(count_q[CNT_W-1:HALF]);
         2'd2: rdata = 8'(prescale_q);
         2'd3: rdata = {3'b000, overflow_q, irqActive, running_q, autoReload_q, enable_q};
         default: rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed self-checking bench for timer_irq_source: one task per scenario, hand-computed expectations.
module tb_timer_irq_source;

   logic       clk;
   logic       reset;
   logic       we;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       s_finish_interr;
   logic       i_timer;
   logic       overflow;

   int nCompared;
   int nMismatched;

   timer_irq_source #(.CNT_W(16), .PRE_W(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .we              (we),
      .addr            (addr),
      .wdata           (wdata),
      .rdata           (rdata),
      .s_finish_interr (s_finish_interr),
      .i_timer         (i_timer),
      .overflow        (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard bound on total runtime in case a scenario stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Register write: driven at negedge, committed on the following posedge.
   task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic ackPulse();
      @(negedge clk);
      s_finish_interr = 1'b1;
      @(posedge clk);
      #1;
      s_finish_interr = 1'b0;
   endtask

   task automatic setAddr(input logic [1:0] a);
      addr = a;
      #1;
   endtask

   task automatic test_reset();
      #12;
      nCompared++;
      if (i_timer !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_irq: got %b expected 0", i_timer);
      end
      nCompared++;
      if (overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ovf: got %b expected 0", overflow);
      end
      for (int a = 0; a < 4; a++) begin
         setAddr(2'(a));
         nCompared++;
         if (rdata !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_reg%0d: got %h expected 00", a, rdata);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_one_shot();
      logic expIrq;
      applyStimulus(2'd0, 8'h03);
      applyStimulus(2'd1, 8'h00);
      applyStimulus(2'd2, 8'h01);
      applyStimulus(2'd3, 8'h01);
      setAddr(2'd0);
      nCompared++;
      if (rdata !== 8'h03) begin
         nMismatched++;
         $display("[TB] FAIL oneshot_load: got %h expected 03", rdata);
      end
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h05) begin
         nMismatched++;
         $display("[TB] FAIL oneshot_status_run: got %h expected 05", rdata);
      end
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         expIrq = (i == 8);
         nCompared++;
         if (i_timer !== expIrq) begin
            nMismatched++;
            $display("[TB] FAIL oneshot_irq_cyc%0d: got %b expected %b", i, i_timer, expIrq);
         end
      end
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h08) begin
         nMismatched++;
         $display("[TB] FAIL oneshot_status_done: got %h expected 08", rdata);
      end
      setAddr(2'd0);
      nCompared++;
      if (rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL oneshot_count_done: got %h expected 00", rdata);
      end
   endtask

   task automatic test_ack();
      repeat (3) @(posedge clk);
      #1;
      nCompared++;
      if (i_timer !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL ack_hold: got %b expected 1", i_timer);
      end
      ackPulse();
      nCompared++;
      if (i_timer !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL ack_clear: got %b expected 0", i_timer);
      end
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL ack_status: got %h expected 00", rdata);
      end
      ackPulse();
      nCompared++;
      if (i_timer !== 1'b0 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL ack_idle_ignored: got irq=%b ovf=%b expected irq=0 ovf=0", i_timer, overflow);
      end
   endtask

   task automatic test_autoreload_overflow();
      logic expIrq;
      logic expOvf;
      applyStimulus(2'd0, 8'h02);
      applyStimulus(2'd1, 8'h00);
      applyStimulus(2'd2, 8'h00);
      applyStimulus(2'd3, 8'h03);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         expIrq = (i >= 3);
         expOvf = (i >= 6);
         nCompared++;
         if (i_timer !== expIrq || overflow !== expOvf) begin
            nMismatched++;
            $display("[TB] FAIL auto_cyc%0d: got irq=%b ovf=%b expected irq=%b ovf=%b",
                     i, i_timer, overflow, expIrq, expOvf);
         end
      end
      applyStimulus(2'd3, 8'h07);
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h0F) begin
         nMismatched++;
         $display("[TB] FAIL auto_ovf_clear: got %h expected 0F", rdata);
      end
      applyStimulus(2'd3, 8'h00);
      ackPulse();
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL auto_cleanup: got %h expected 00", rdata);
      end
   endtask

   task automatic test_coincident();
      applyStimulus(2'd3, 8'h03);
      repeat (3) @(posedge clk);
      #1;
      nCompared++;
      if (i_timer !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL coinc_first: got %b expected 1", i_timer);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      s_finish_interr = 1'b1;
      @(posedge clk);
      #1;
      s_finish_interr = 1'b0;
      nCompared++;
      if (i_timer !== 1'b1 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL coinc_edge: got irq=%b ovf=%b expected irq=1 ovf=0", i_timer, overflow);
      end
      @(posedge clk);
      #1;
      nCompared++;
      if (i_timer !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL coinc_after: got %b expected 1", i_timer);
      end
      applyStimulus(2'd3, 8'h00);
      ackPulse();
      nCompared++;
      if (i_timer !== 1'b0 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL coinc_cleanup: got irq=%b ovf=%b expected irq=0 ovf=0", i_timer, overflow);
      end
   endtask

   task automatic test_every_cycle();
      applyStimulus(2'd0, 8'h00);
      applyStimulus(2'd3, 8'h03);
      @(posedge clk);
      #1;
      nCompared++;
      if (i_timer !== 1'b1 || overflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL every_first: got irq=%b ovf=%b expected irq=1 ovf=0", i_timer, overflow);
      end
      @(posedge clk);
      #1;
      nCompared++;
      if (overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL every_ovf: got %b expected 1", overflow);
      end
      // Clear lands on an expiry edge, so the new overflow wins.
      applyStimulus(2'd3, 8'h04);
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h18) begin
         nMismatched++;
         $display("[TB] FAIL every_set_wins: got %h expected 18", rdata);
      end
      applyStimulus(2'd3, 8'h04);
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h08) begin
         nMismatched++;
         $display("[TB] FAIL every_clear: got %h expected 08", rdata);
      end
      ackPulse();
      nCompared++;
      if (i_timer !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL every_ack: got %b expected 0", i_timer);
      end
   endtask

   task automatic test_disable_reload();
      applyStimulus(2'd0, 8'h00);
      applyStimulus(2'd1, 8'h01);
      applyStimulus(2'd2, 8'h01);
      applyStimulus(2'd3, 8'h01);
      applyStimulus(2'd0, 8'h33);
      repeat (7) @(posedge clk);
      #1;
      setAddr(2'd0);
      nCompared++;
      if (rdata !== 8'hFC) begin
         nMismatched++;
         $display("[TB] FAIL dis_running_count: got %h expected FC", rdata);
      end
      applyStimulus(2'd3, 8'h00);
      repeat (5) @(posedge clk);
      #1;
      setAddr(2'd0);
      nCompared++;
      if (rdata !== 8'hFC) begin
         nMismatched++;
         $display("[TB] FAIL dis_frozen_lo: got %h expected FC", rdata);
      end
      setAddr(2'd1);
      nCompared++;
      if (rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL dis_frozen_hi: got %h expected 00", rdata);
      end
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL dis_status: got %h expected 00", rdata);
      end
      applyStimulus(2'd0, 8'h05);
      applyStimulus(2'd1, 8'h00);
      applyStimulus(2'd3, 8'h01);
      setAddr(2'd0);
      nCompared++;
      if (rdata !== 8'h05) begin
         nMismatched++;
         $display("[TB] FAIL dis_reload_lo: got %h expected 05", rdata);
      end
      setAddr(2'd2);
      nCompared++;
      if (rdata !== 8'h01) begin
         nMismatched++;
         $display("[TB] FAIL dis_prescale: got %h expected 01", rdata);
      end
      applyStimulus(2'd3, 8'h00);
   endtask

   task automatic test_reset_pend();
      applyStimulus(2'd0, 8'h02);
      applyStimulus(2'd1, 8'h00);
      applyStimulus(2'd2, 8'h00);
      applyStimulus(2'd3, 8'h03);
      addr = 2'd3;
      repeat (6) @(posedge clk);
      @(negedge clk);
      nCompared++;
      if (i_timer !== 1'b1 || overflow !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL rst_pend_setup: got irq=%b ovf=%b expected irq=1 ovf=1", i_timer, overflow);
      end
      #2;
      reset = 1'b1;
      #1;
      nCompared++;
      if (i_timer !== 1'b0 || overflow !== 1'b0 || rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL rst_async: got irq=%b ovf=%b status=%h expected 0 0 00",
                  i_timer, overflow, rdata);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      we    = 1'b1;
      addr  = 2'd2;
      wdata = 8'h5A;
      @(posedge clk);
      #1;
      we = 1'b0;
      setAddr(2'd2);
      nCompared++;
      if (rdata !== 8'h5A) begin
         nMismatched++;
         $display("[TB] FAIL rst_first_write: got %h expected 5A", rdata);
      end
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         nCompared++;
         if (i_timer !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rst_quiet_cyc%0d: got %b expected 0", i, i_timer);
         end
      end
      setAddr(2'd3);
      nCompared++;
      if (rdata !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL rst_final_status: got %h expected 00", rdata);
      end
   endtask

   initial begin
      nCompared       = 0;
      nMismatched     = 0;
      reset           = 1'b1;
      we              = 1'b0;
      addr            = 2'd0;
      wdata           = 8'h00;
      s_finish_interr = 1'b0;

      test_reset();
      test_one_shot();
      test_ack();
      test_autoreload_overflow();
      test_coincident();
      test_every_cycle();
      test_disable_reload();
      test_reset_pend();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
